// File: rtl/rfblackwidow_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rfBlackWidowPkg
// Description : Shared types and constants for the register-file writeback
//               path. It provides the Value and CodeAddress datatypes, the
//               writeback request record WbReq, the writeback port and
//               requester counts, and a saturating 32-bit increment helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rfBlackWidowPkg;

  localparam int VALUE_W = 64;
  localparam int CADDR_W = 32;
  localparam int TGT_W   = 6;

  typedef logic [VALUE_W-1:0] Value;
  typedef logic [CADDR_W-1:0] CodeAddress;

  // One writeback slot. Output ports of the scheduler are registered in
  // exactly this shape.
  typedef struct packed {
    logic             v;
    logic [TGT_W-1:0] tgt;
    Value             val;
    CodeAddress       ip;
  } WbReq;

  localparam int NWB_PORTS = 3;
  localparam int NWB_REQ   = 5;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rfblackwidow_wb_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rfblackwidow_wb_pick
// Description : Purely combinational rotated-priority selector. It scans the
//               requesters starting at rr and wrapping modulo NREQ. A request
//               to r0 is acknowledged and dropped without taking a port. Any
//               other request takes the next free port, unless its target
//               matches a target already granted in this scan.
// Ports       : valid_i    - per-requester request valid
//               tgt_i      - per-requester target register
//               rr_i       - first requester in the scan order
//               ready_o    - per-requester acknowledge (raw, not gated)
//               port_vld_o - port k carries a grant
//               port_idx_o - requester index assigned to port k
//               collide_o  - some requester lost only to a same-target grant
// Revision    : 1.0 - initial release
// ============================================================================
module rfblackwidow_wb_pick
  import rfBlackWidowPkg::*;
#(
  parameter  int NREQ  = NWB_REQ,
  parameter  int NPORT = NWB_PORTS,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]             valid_i,
  input  logic [NREQ-1:0][TGT_W-1:0]  tgt_i,
  input  logic [IDX_W-1:0]            rr_i,
  output logic [NREQ-1:0]             ready_o,
  output logic [NPORT-1:0]            port_vld_o,
  output logic [NPORT-1:0][IDX_W-1:0] port_idx_o,
  output logic                        collide_o
);

  localparam int               CNT_W    = $clog2(NPORT + 1);
  localparam logic [CNT_W-1:0] PORT_LIM = CNT_W'(NPORT);
  localparam logic [IDX_W:0]   NREQ_X   = (IDX_W + 1)'(NREQ);

  logic [CNT_W-1:0]            n_grant;
  logic [NPORT-1:0][TGT_W-1:0] taken_tgt;
  logic [IDX_W:0]              scan;
  logic [IDX_W-1:0]            j;
  logic                        hit;

  always_comb begin
    ready_o    = '0;
    port_vld_o = '0;
    port_idx_o = '0;
    collide_o  = 1'b0;
    n_grant    = '0;
    taken_tgt  = '0;
    scan       = '0;
    j          = '0;
    hit        = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // rr + i is always below 2*NREQ, so a single subtract is the modulo.
      scan = {1'b0, rr_i} + (IDX_W + 1)'(i);
      if (scan >= NREQ_X) scan = scan - NREQ_X;
      j = scan[IDX_W-1:0];
      if (valid_i[j]) begin
        if (tgt_i[j] == '0) begin
          ready_o[j] = 1'b1;
        end else begin
          hit = 1'b0;
          for (int k = 0; k < NPORT; k++) begin
            if (port_vld_o[k] && (taken_tgt[k] == tgt_i[j])) hit = 1'b1;
          end
          // Count a collision only while a port is still free. A requester
          // that would be refused anyway for lack of ports is not counted.
          if (n_grant < PORT_LIM) begin
            if (hit) begin
              collide_o = 1'b1;
            end else begin
              ready_o[j]          = 1'b1;
              port_vld_o[n_grant] = 1'b1;
              port_idx_o[n_grant] = j;
              taken_tgt[n_grant]  = tgt_i[j];
              n_grant             = n_grant + CNT_W'(1);
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rfblackwidow_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rfblackwidow_wb_arbiter
// Description : Writeback scheduler in front of the 3-write-port register
//               file. It grants up to NPORT non-conflicting writes per cycle
//               in rotating round-robin order and registers them onto the
//               regfile write ports.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               hold_i          - pipeline freeze, no grants while high
//               req_valid_i     - per-requester write request
//               req_tgt_i       - target register per requester
//               req_val_i       - result value per requester
//               req_ip_i        - producer instruction address per requester
//               req_ready_o     - grant; transfer on valid & ready
//               wr_o/wa_o       - registered write enable / address per port
//               wdat_o/wip_o    - registered write data / producer address
//               conflict_cnt_o  - saturating same-target collision cycles
//               busy_o          - some valid requester was not granted
// Revision    : 1.0 - initial release
// ============================================================================
module rfblackwidow_wb_arbiter
  import rfBlackWidowPkg::*;
#(
  parameter int NREQ  = NWB_REQ,
  parameter int NPORT = NWB_PORTS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold_i,
  input  logic [NREQ-1:0]               req_valid_i,
  input  logic [NREQ-1:0][TGT_W-1:0]    req_tgt_i,
  input  logic [NREQ-1:0][VALUE_W-1:0]  req_val_i,
  input  logic [NREQ-1:0][CADDR_W-1:0]  req_ip_i,
  output logic [NREQ-1:0]               req_ready_o,
  output logic [NPORT-1:0]              wr_o,
  output logic [NPORT-1:0][TGT_W-1:0]   wa_o,
  output logic [NPORT-1:0][VALUE_W-1:0] wdat_o,
  output logic [NPORT-1:0][CADDR_W-1:0] wip_o,
  output logic [31:0]                   conflict_cnt_o,
  output logic                          busy_o
);

  localparam int               IDX_W    = $clog2(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  logic [IDX_W-1:0]            rr_q, rr_d;
  logic [31:0]                 cnt_q, cnt_d;
  WbReq [NPORT-1:0]            port_q, port_d;
  logic [IDX_W-1:0]            last_idx;

  logic [NREQ-1:0]             pick_ready;
  logic [NPORT-1:0]            port_vld;
  logic [NPORT-1:0][IDX_W-1:0] port_idx;
  logic                        collide;
  logic                        active;

  rfblackwidow_wb_pick #(
    .NREQ  (NREQ),
    .NPORT (NPORT)
  ) u_pick (
    .valid_i    (req_valid_i),
    .tgt_i      (req_tgt_i),
    .rr_i       (rr_q),
    .ready_o    (pick_ready),
    .port_vld_o (port_vld),
    .port_idx_o (port_idx),
    .collide_o  (collide)
  );

  assign active      = !rst && !hold_i;
  assign req_ready_o = active ? pick_ready : '0;
  assign busy_o      = |(req_valid_i & ~req_ready_o);

  always_comb begin
    port_d   = port_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    last_idx = '0;
    for (int k = 0; k < NPORT; k++) begin
      // Idle ports drop the enable but keep address, data and ip.
      port_d[k].v = 1'b0;
      if (active && port_vld[k]) begin
        port_d[k].v   = 1'b1;
        port_d[k].tgt = req_tgt_i[port_idx[k]];
        port_d[k].val = req_val_i[port_idx[k]];
        port_d[k].ip  = req_ip_i[port_idx[k]];
      end
      // Ports fill in scan order, so the highest used port holds the
      // last requester granted in the scan.
      if (port_vld[k]) last_idx = port_idx[k];
    end
    if (active && (|port_vld)) begin
      rr_d = (last_idx == LAST_IDX) ? '0 : last_idx + IDX_W'(1);
    end
    if (active && collide) cnt_d = sat_inc32(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= '0;
      cnt_q  <= '0;
      port_q <= '0;
    end else begin
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
      port_q <= port_d;
    end
  end

  generate
    for (genvar k = 0; k < NPORT; k++) begin : g_port
      assign wr_o[k]   = port_q[k].v;
      assign wa_o[k]   = port_q[k].tgt;
      assign wdat_o[k] = port_q[k].val;
      assign wip_o[k]  = port_q[k].ip;
    end
  endgenerate

  assign conflict_cnt_o = cnt_q;

  // A waiting requester must keep its request and payload unchanged until
  // it is accepted. Requests pending across a reset are dropped, so the
  // cycle after reset is exempt.
  generate
    for (genvar j = 0; j < NREQ; j++) begin : g_req_chk
      a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        ($past(req_valid_i[j]) && !$past(req_ready_o[j]) && !$past(rst))
          |-> (req_valid_i[j] && $stable(req_tgt_i[j]) &&
               $stable(req_val_i[j]) && $stable(req_ip_i[j])));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rfblackwidow_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rfblackwidow_wb_arbiter
// Description : Self-checking bench for the writeback scheduler. It runs
//               directed scenarios and then randomized traffic against a
//               queue-based reference model of the grant rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rfblackwidow_wb_arbiter;
  import rfBlackWidowPkg::*;

  localparam int NREQ  = 5;
  localparam int NPORT = 3;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          hold;
  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0]               req_ready;
  logic [NREQ-1:0][TGT_W-1:0]    req_tgt;
  logic [NREQ-1:0][VALUE_W-1:0]  req_val;
  logic [NREQ-1:0][CADDR_W-1:0]  req_ip;
  logic [NPORT-1:0]              wr;
  logic [NPORT-1:0][TGT_W-1:0]   wa;
  logic [NPORT-1:0][VALUE_W-1:0] wdat;
  logic [NPORT-1:0][CADDR_W-1:0] wip;
  logic [31:0]                   conflict_cnt;
  logic                          busy;

  int n_tests = 0;
  int n_fail  = 0;

  rfblackwidow_wb_arbiter #(.NREQ(NREQ), .NPORT(NPORT)) dut (
    .clk            (clk),
    .rst            (rst),
    .hold_i         (hold),
    .req_valid_i    (req_valid),
    .req_tgt_i      (req_tgt),
    .req_val_i      (req_val),
    .req_ip_i       (req_ip),
    .req_ready_o    (req_ready),
    .wr_o           (wr),
    .wa_o           (wa),
    .wdat_o         (wdat),
    .wip_o          (wip),
    .conflict_cnt_o (conflict_cnt),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  int              m_rr;
  logic [31:0]     m_cnt;
  bit              m_wr  [NPORT];
  int              m_wa  [NPORT];
  logic [63:0]     m_wd  [NPORT];
  logic [31:0]     m_wip [NPORT];
  int              m_g[$];
  logic [NREQ-1:0] m_rdy;
  bit              m_coll;
  logic [NREQ-1:0] seen_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant rules applied to the current inputs.
  function automatic void model_pick();
    int tg[$];
    m_g.delete();
    m_rdy  = '0;
    m_coll = 1'b0;
    if (rst || hold) return;
    for (int i = 0; i < NREQ; i++) begin
      int  j;
      bit  hit;
      j   = (m_rr + i) % NREQ;
      hit = 1'b0;
      if (!req_valid[j]) continue;
      if (req_tgt[j] == 0) begin
        m_rdy[j] = 1'b1;
        continue;
      end
      foreach (tg[k]) if (tg[k] == int'(req_tgt[j])) hit = 1'b1;
      if (m_g.size() < NPORT) begin
        if (hit) m_coll = 1'b1;
        else begin
          m_rdy[j] = 1'b1;
          m_g.push_back(j);
          tg.push_back(int'(req_tgt[j]));
        end
      end
    end
  endfunction

  // State change at the clock edge.
  function automatic void model_apply();
    if (rst) begin
      m_rr  = 0;
      m_cnt = 0;
      for (int k = 0; k < NPORT; k++) begin
        m_wr[k] = 0; m_wa[k] = 0; m_wd[k] = 0; m_wip[k] = 0;
      end
    end else if (hold) begin
      for (int k = 0; k < NPORT; k++) m_wr[k] = 0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        if (k < m_g.size()) begin
          int j;
          j        = m_g[k];
          m_wr[k]  = 1;
          m_wa[k]  = int'(req_tgt[j]);
          m_wd[k]  = req_val[j];
          m_wip[k] = req_ip[j];
        end else begin
          m_wr[k] = 0;
        end
      end
      if (m_g.size() > 0) m_rr = (m_g[m_g.size()-1] + 1) % NREQ;
      if (m_coll && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic cycle();
    logic [NPORT-1:0] ew;
    #3;
    model_pick();
    seen_rdy = req_ready;
    chk("ready", req_ready, m_rdy);
    chk("busy", busy, |(req_valid & ~m_rdy));
    @(posedge clk);
    #1;
    model_apply();
    for (int k = 0; k < NPORT; k++) ew[k] = m_wr[k];
    chk("wr", wr, ew);
    for (int k = 0; k < NPORT; k++) begin
      chk($sformatf("wa%0d", k), wa[k], m_wa[k]);
      chk($sformatf("wdat%0d", k), wdat[k], m_wd[k]);
      chk($sformatf("wip%0d", k), wip[k], m_wip[k]);
    end
    chk("conflict_cnt", conflict_cnt, m_cnt);
  endtask

  task automatic load(input int j, input int t);
    req_valid[j] = 1'b1;
    req_tgt[j]   = TGT_W'(t);
    req_val[j]   = {$urandom, $urandom};
    req_ip[j]    = $urandom;
  endtask

  // Retire transferred requests (all of them after a reset), then
  // randomly raise new ones on idle requesters.
  task automatic advance(input int pct_new);
    for (int j = 0; j < NREQ; j++) begin
      if (rst || (req_valid[j] && m_rdy[j])) req_valid[j] = 1'b0;
      if (!req_valid[j] && ($urandom_range(99) < pct_new)) begin
        if ($urandom_range(3) == 0) load(j, $urandom_range(63));
        else                        load(j, $urandom_range(7));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    req_valid = '0; req_tgt = '0; req_val = '0; req_ip = '0;
    #1;
    cycle();
    chk("rst_wr", wr, 3'b000);
    chk("rst_cnt", conflict_cnt, 32'd0);
    rst = 1'b0;

    // Three distinct targets from rr=0
    load(0, 3); load(1, 4); load(2, 5);
    cycle();
    chk("t1_ready", seen_rdy, 5'b00111);
    chk("t1_wr", wr, 3'b111);
    chk("t1_wa", wa, {6'd5, 6'd4, 6'd3});

    // All five valid: two cycles of grants
    do_reset();
    for (int j = 0; j < NREQ; j++) load(j, j + 1);
    cycle();
    chk("t2_ready0", seen_rdy, 5'b00111);
    advance(0);
    cycle();
    chk("t2_ready1", seen_rdy, 5'b11000);
    chk("t2_wr", wr, 3'b011);
    chk("t2_wa0", wa[0], 6'd4);
    chk("t2_wa1", wa[1], 6'd5);

    // Same-target collision
    do_reset();
    load(0, 7); load(1, 7);
    cycle();
    chk("t3_ready0", seen_rdy, 5'b00001);
    chk("t3_cnt", conflict_cnt, 32'd1);
    advance(0);
    cycle();
    chk("t3_ready1", seen_rdy, 5'b00010);
    chk("t3_wr", wr, 3'b001);
    chk("t3_wa0", wa[0], 6'd7);

    // r0 write is discarded and leaves rr alone
    do_reset();
    load(2, 0);
    cycle();
    chk("t4_ready", seen_rdy, 5'b00100);
    chk("t4_wr", wr, 3'b000);
    advance(0);
    load(1, 6); load(4, 6);
    cycle();
    chk("t4_rr", seen_rdy, 5'b00010);

    // Hold freezes grants for four cycles
    do_reset();
    load(0, 1); load(1, 1); load(2, 2); load(3, 3); load(4, 4);
    hold = 1'b1;
    repeat (4) begin
      cycle();
      chk("t5_hold_ready", seen_rdy, 5'b00000);
      chk("t5_hold_wr", wr, 3'b000);
    end
    hold = 1'b0;
    cycle();
    chk("t5_release", seen_rdy, 5'b01101);
    chk("t5_cnt", conflict_cnt, 32'd1);

    // Reset with requests pending
    rst = 1'b1;
    for (int j = 0; j < NREQ; j++) load(j, j + 11);
    cycle();
    chk("t6_wr", wr, 3'b000);
    chk("t6_cnt", conflict_cnt, 32'd0);
    rst = 1'b0;
    cycle();
    chk("t6_rr", seen_rdy, 5'b00111);

    // Randomized traffic
    advance(0);
    do_reset();
    repeat (2000) begin
      hold = ($urandom_range(7) == 0);
      rst  = ($urandom_range(199) == 0);
      cycle();
      advance(40);
    end
    rst  = 1'b0;
    hold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
